fp_expand: RTL and testbench

Sequential decoder stage directly downstream of the 12-bit floating-point converter. It accepts one sign, 3-bit exponent and 4-bit significand triple per transaction and reconstructs the 12-bit two's-complement value: magnitude is F shifted left by E, negated if S. The shift is iterative (one bit per cycle), so the block is used to check converter round-trip error on hardware and to drive the display path with the quantized value. Valid/ready handshakes are used on both sides.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_expand.sv | 81 ++++++++
 tb/tb_fp_expand.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the 12-bit floating-point converter family: field widths
// and the expander state encoding used by the RTL and its benches.
package fp_pkg;

    localparam int unsigned EXP_W = 3;
    localparam int unsigned SIG_W = 4;
    localparam int unsigned OUT_W = 12;

    // Smallest output width that holds F << (2^EXP_W - 1) plus a sign bit.
    localparam int unsigned MIN_OUT_W = SIG_W + (1 << EXP_W) - 1 + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StSign,
        StDone
    } fp_state_e;

endpackage

// File: rtl/fp_expand.sv
// Sequential floating-point expander: rebuilds the two's-complement value
// (-1)^S * F * 2^E from a sign/exponent/significand triple, shifting one bit
// per cycle. Valid/ready handshakes on both the input and the output side.
module fp_expand
    import fp_pkg::*;
#(
    parameter int unsigned ExpW = EXP_W,
    parameter int unsigned SigW = SIG_W,
    parameter int unsigned OutW = OUT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            s,
    input  logic [ExpW-1:0] e,
    input  logic [SigW-1:0] f,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OutW-1:0] d
);

    fp_state_e       state_q;
    logic [OutW-1:0] mag_q;
    logic [ExpW-1:0] cnt_q;
    logic            sgn_q;
    logic            out_valid_q;
    logic [OutW-1:0] d_q;

    // Only the idle state accepts a triple; anything offered while busy is ignored.
    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign d         = d_q;

    // Control FSM with the shift register, down-counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mag_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            d_q         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        mag_q   <= OutW'(f);
                        cnt_q   <= e;
                        sgn_q   <= s;
                        // A zero exponent needs no shifting at all.
                        state_q <= (e != '0) ? StShift : StSign;
                    end
                end
                StShift: begin
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q - ExpW'(1);
                    if (cnt_q == ExpW'(1)) begin
                        state_q <= StSign;
                    end
                end
                StSign: begin
                    // Negating zero yields zero, so F = 0 gives 0 for either sign.
                    d_q         <= sgn_q ? (~mag_q + OutW'(1)) : mag_q;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_expand.sv
// Bench for fp_expand: directed cases plus randomized triples checked against an
// arithmetic reference value and an e + 1 cycle latency expectation.
module tb_fp_expand;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] d;

    int checks;
    int failures;

    fp_expand dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .e         (e),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: (-1)^s * f * 2^e, wrapped to 12 bits.
    function automatic logic [11:0] model(input bit sv, input int ev, input int fv);
        int v;
        v = fv * (1 << ev);
        if (sv) v = -v;
        return v[11:0];
    endfunction

    // One full transaction: accept, latency, result, optional backpressure, handshake.
    task automatic xact(input bit sv, input int ev, input int fv, input bit early,
                        input int hold, input bit poke);
        int          waitc;
        int          cyc;
        logic [11:0] exp;
        exp   = model(sv, ev, fv);
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            step();
            waitc++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        s         = sv;
        e         = ev[2:0];
        f         = fv[3:0];
        in_valid  = 1'b1;
        out_ready = early;
        step();
        in_valid = 1'b0;
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("latency", cyc, ev + 1);
        chk("out_valid_set", {31'd0, out_valid}, 32'd1);
        chk("d_result", {20'd0, d}, {20'd0, exp});
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                if (poke) begin
                    in_valid = 1'b1;
                    s        = $urandom_range(0, 1);
                    e        = 3'($urandom_range(0, 7));
                    f        = 4'($urandom_range(1, 15));
                end
                step();
                chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_d", {20'd0, d}, {20'd0, exp});
                chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_clear", {31'd0, out_valid}, 32'd0);
        chk("in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("d_kept", {20'd0, d}, {20'd0, exp});
        // A triple poked during backpressure must not have started a new transaction.
        step();
        chk("idle_stays", {31'd0, in_ready}, 32'd1);
        chk("no_spurious_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = 1'b0;
        e         = 3'd0;
        f         = 4'd0;

        step();
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", {20'd0, d}, 32'h000);
        rst_n = 1'b1;
        step();

        // Directed cases from the test plan.
        xact(1'b0, 0, 4'b1000, 1'b1, 0, 1'b0);
        xact(1'b1, 5, 4'b1110, 1'b1, 0, 1'b0);
        chk("neg_448", {20'd0, d}, 32'hE40);
        xact(1'b0, 7, 4'b1111, 1'b1, 0, 1'b0);
        chk("max_1920", {20'd0, d}, 32'h780);
        xact(1'b1, 7, 4'b1111, 1'b0, 1, 1'b0);
        xact(1'b1, 3, 4'b0000, 1'b1, 0, 1'b0);
        chk("neg_zero", {20'd0, d}, 32'h000);
        // Backpressure with new triples offered while the result waits.
        xact(1'b1, 2, 4'b0101, 1'b0, 3, 1'b1);

        // Reset in the middle of shifting discards the transaction.
        s        = 1'b1;
        e        = 3'd6;
        f        = 4'b1000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_d", {20'd0, d}, 32'h000);
        rst_n = 1'b1;
        step();
        chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        xact(1'b0, 3, 4'b1000, 1'b1, 0, 1'b0);
        chk("after_rst_d", {20'd0, d}, 32'h040);

        // Randomized transactions with random gaps and backpressure.
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            xact(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
